// File: rtl/lv_reg_rd_arb_pkg.sv
// Shared types and default constants for the low-voltage register-file read arbiter.
package lv_reg_rd_arb_pkg;

  localparam int unsigned DEF_REG_AW    = 7;
  localparam int unsigned DEF_REG_DW    = 8;
  localparam int unsigned DEF_REG_CRC_W = 8;
  localparam int unsigned DEF_RD_TMO    = 16;
  localparam int unsigned DEF_STARVE_TH = 4;

  localparam int unsigned N_REQ    = 3;
  localparam int unsigned IDX_SPI  = 0;
  localparam int unsigned IDX_BIST = 1;
  localparam int unsigned IDX_WDG  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_SPI  = 2'd0,
    REQ_BIST = 2'd1,
    REQ_WDG  = 2'd2
  } req_id_e;

  function automatic logic [N_REQ-1:0] id_to_oh(input req_id_e id);
    logic [N_REQ-1:0] oh;
    oh = '0;
    case (id)
      REQ_SPI:  oh[IDX_SPI]  = 1'b1;
      REQ_BIST: oh[IDX_BIST] = 1'b1;
      REQ_WDG:  oh[IDX_WDG]  = 1'b1;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

  // Grant vectors are one-hot, so the last set bit identifies the winner.
  function automatic req_id_e oh_to_id(input logic [N_REQ-1:0] oh);
    req_id_e id;
    id = REQ_SPI;
    if (oh[IDX_BIST]) id = REQ_BIST;
    if (oh[IDX_WDG])  id = REQ_WDG;
    return id;
  endfunction

endpackage

// File: rtl/lv_pri_arb.sv
// Combinational fixed-priority pick (SPI > BIST > WDG) with per-requester mask
// and a promote input that lets a pending WDG beat everything.
module lv_pri_arb
  import lv_reg_rd_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_mask,
  input  logic             i_promote,
  output logic [N_REQ-1:0] o_gnt_c
);

  logic [N_REQ-1:0] elig;

  always_comb begin
    elig    = i_req & ~i_mask;
    o_gnt_c = '0;
    if (i_promote && elig[IDX_WDG]) begin
      o_gnt_c[IDX_WDG] = 1'b1;
    end else if (elig[IDX_SPI]) begin
      o_gnt_c[IDX_SPI] = 1'b1;
    end else if (elig[IDX_BIST]) begin
      o_gnt_c[IDX_BIST] = 1'b1;
    end else if (elig[IDX_WDG]) begin
      o_gnt_c[IDX_WDG] = 1'b1;
    end
  end

endmodule

// File: rtl/lv_reg_rd_arb.sv
// Serialises SPI / BIST / WDG reads onto the LV register file's single read port
// and returns data, CRC and a timeout flag on a shared response bus.
module lv_reg_rd_arb
  import lv_reg_rd_arb_pkg::*;
#(
  parameter int unsigned REG_AW    = DEF_REG_AW,
  parameter int unsigned REG_DW    = DEF_REG_DW,
  parameter int unsigned REG_CRC_W = DEF_REG_CRC_W,
  parameter int unsigned RD_TMO    = DEF_RD_TMO,
  parameter int unsigned STARVE_TH = DEF_STARVE_TH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_spi_rd_req,
  input  logic                 i_bist_rd_req,
  input  logic                 i_wdg_rd_req,
  input  logic [REG_AW-1:0]    i_spi_rd_addr,
  input  logic [REG_AW-1:0]    i_bist_rd_addr,
  input  logic [REG_AW-1:0]    i_wdg_rd_addr,
  output logic                 o_spi_rd_ack,
  output logic                 o_bist_rd_ack,
  output logic                 o_wdg_rd_ack,
  output logic [REG_DW-1:0]    o_rd_data,
  output logic [REG_CRC_W-1:0] o_rd_crc,
  output logic                 o_rd_err,
  output logic                 o_reg_rd_en,
  output logic [REG_AW-1:0]    o_reg_rd_addr,
  input  logic                 i_reg_rd_vld,
  input  logic [REG_DW-1:0]    i_reg_rd_data,
  input  logic [REG_CRC_W-1:0] i_reg_rd_crc,
  output logic                 o_arb_busy
);

  localparam int unsigned TMO_W = (RD_TMO > 1) ? $clog2(RD_TMO) : 1;
  localparam int unsigned STV_W = $clog2(STARVE_TH + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TMO - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_TH);

  arb_state_e           state_q, state_d;
  req_id_e              gnt_id_q, gnt_id_d;
  logic [REG_AW-1:0]    addr_q, addr_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [STV_W-1:0]     starve_q, starve_d;
  logic [N_REQ-1:0]     mask_q, mask_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [REG_DW-1:0]    data_q, data_d;
  logic [REG_CRC_W-1:0] crc_q, crc_d;
  logic                 err_q, err_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;

  logic [N_REQ-1:0]     req_c, gnt_c;
  logic                 promote_c, win_c, wdg_pend_c, tmo_hit_c;

  assign req_c      = {i_wdg_rd_req, i_bist_rd_req, i_spi_rd_req};
  assign promote_c  = (starve_q == STV_MAX);
  assign win_c      = |gnt_c;
  assign wdg_pend_c = i_wdg_rd_req & ~mask_q[IDX_WDG];
  assign tmo_hit_c  = (tmo_cnt_q == TMO_LAST);

  lv_pri_arb u_pri_arb (
    .i_req     (req_c),
    .i_mask    (mask_q),
    .i_promote (promote_c),
    .o_gnt_c   (gnt_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_c) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (i_reg_rd_vld || tmo_hit_c) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; strobes are derived from the next state.
  always_comb begin
    gnt_id_d  = gnt_id_q;
    addr_d    = addr_q;
    tmo_cnt_d = '0;
    starve_d  = starve_q;
    data_d    = data_q;
    crc_d     = crc_q;
    err_d     = err_q;

    if (state_q == ST_IDLE && win_c) begin
      gnt_id_d = oh_to_id(gnt_c);
      if (gnt_c[IDX_WDG])       addr_d = i_wdg_rd_addr;
      else if (gnt_c[IDX_BIST]) addr_d = i_bist_rd_addr;
      else                      addr_d = i_spi_rd_addr;
    end

    if (state_q == ST_IDLE) begin
      if (!wdg_pend_c || gnt_c[IDX_WDG]) begin
        starve_d = '0;
      end else if (win_c && (starve_q != STV_MAX)) begin
        starve_d = starve_q + STV_W'(1);
      end
    end

    if (state_q == ST_WAIT) begin
      if (!tmo_hit_c) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      // A return on the last timeout cycle still counts as a good read.
      if (i_reg_rd_vld) begin
        data_d = i_reg_rd_data;
        crc_d  = i_reg_rd_crc;
        err_d  = 1'b0;
      end else if (tmo_hit_c) begin
        data_d = '0;
        crc_d  = '0;
        err_d  = 1'b1;
      end
    end

    rd_en_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
    ack_d   = (state_d == ST_RESP) ? id_to_oh(gnt_id_q) : '0;
    mask_d  = (state_q == ST_RESP) ? id_to_oh(gnt_id_q) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gnt_id_q  <= REQ_SPI;
      addr_q    <= '0;
      tmo_cnt_q <= '0;
      starve_q  <= '0;
      mask_q    <= '0;
      ack_q     <= '0;
      data_q    <= '0;
      crc_q     <= '0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      gnt_id_q  <= gnt_id_d;
      addr_q    <= addr_d;
      tmo_cnt_q <= tmo_cnt_d;
      starve_q  <= starve_d;
      mask_q    <= mask_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
    end
  end

  assign o_spi_rd_ack  = ack_q[IDX_SPI];
  assign o_bist_rd_ack = ack_q[IDX_BIST];
  assign o_wdg_rd_ack  = ack_q[IDX_WDG];
  assign o_rd_data     = data_q;
  assign o_rd_crc      = crc_q;
  assign o_rd_err      = err_q;
  assign o_reg_rd_en   = rd_en_q;
  assign o_reg_rd_addr = addr_q;
  assign o_arb_busy    = busy_q;

endmodule
